// File: rtl/crc_stream.sv
// Streaming MSB-first CRC engine with generate (append) and check modes.
// Single output register stage; valid/ready on both sides.
module crc_stream #(
    parameter int              DW   = 32,
    parameter int              CW   = 8,
    parameter logic [CW-1:0]   POLY = 8'h31,
    parameter logic [CW-1:0]   INIT = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          crc_mode,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          m_err
);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        APPEND
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          mode_q;
    logic          mode_d;
    logic [CW-1:0] crc_q;
    logic [CW-1:0] crc_d;

    logic          accept;
    logic          out_free;
    logic          cur_mode;
    logic [CW-1:0] crc_base;
    logic [CW-1:0] crc_calc;
    logic          crc_ok;
    logic [DW-1:0] crc_ext;

    logic          load;
    logic [DW-1:0] data_d;
    logic          last_d;
    logic          err_d;

    function automatic logic [CW-1:0] crc_step(
        input logic [CW-1:0] c,
        input logic [DW-1:0] d
    );
        logic [CW-1:0] r;
        logic          fb;
        r = c;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = r[CW-1] ^ d[i];
            r  = (r << 1) ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    // Ready is held low during reset so nothing is taken before release.
    assign out_free = !m_valid || m_ready;
    assign s_ready  = rst_n && (state_q != APPEND) && out_free;
    assign accept   = s_valid && s_ready;

    // First beat of a packet samples the mode and seeds from INIT.
    assign cur_mode = (state_q == IDLE) ? crc_mode : mode_q;
    assign crc_base = (state_q == IDLE) ? INIT : crc_q;
    assign crc_calc = crc_step(crc_base, s_data);
    assign crc_ok   = (s_data[CW-1:0] == crc_base);

    always_comb begin
        crc_ext          = '0;
        crc_ext[CW-1:0]  = crc_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, PASS: begin
                if (accept) begin
                    if (!s_last) begin
                        state_d = PASS;
                    end else if (cur_mode) begin
                        state_d = IDLE;
                    end else begin
                        state_d = APPEND;
                    end
                end
            end
            APPEND: begin
                if (out_free) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        load   = 1'b0;
        data_d = s_data;
        last_d = 1'b0;
        err_d  = 1'b0;
        crc_d  = crc_q;
        mode_d = mode_q;
        if (state_q == APPEND) begin
            data_d = crc_ext;
            last_d = 1'b1;
            if (out_free) begin
                load  = 1'b1;
                crc_d = INIT;
            end
        end else if (accept) begin
            load   = 1'b1;
            mode_d = cur_mode;
            if (cur_mode && s_last) begin
                last_d = 1'b1;
                err_d  = !crc_ok;
                crc_d  = INIT;
            end else begin
                crc_d  = crc_calc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q   <= INIT;
            mode_q  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            crc_q  <= crc_d;
            mode_q <= mode_d;
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= data_d;
                m_last  <= last_d;
                m_err   <= err_d;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                m_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench for crc_stream (DW=32, CW=8, POLY=0x31, INIT=0).
// Output beats are collected into a queue and compared in order.
module tb_crc_stream;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        crc_mode = 1'b0;
    logic        s_valid  = 1'b0;
    logic        s_ready;
    logic [31:0] s_data   = '0;
    logic        s_last   = 1'b0;
    logic        m_valid;
    logic        m_ready  = 1'b1;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_err;

    int          checks = 0;
    int          errs   = 0;
    logic [33:0] q[$];

    always #5 clk = ~clk;

    crc_stream dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .crc_mode(crc_mode),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_err   (m_err)
    );

    always @(negedge clk)
        if (rst_n && m_valid && m_ready)
            q.push_back({m_err, m_last, m_data});

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called aligned just after a rising edge; returns likewise.
    task automatic send(input logic [31:0] d, input logic l,
                        input logic md);
        int n = 0;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = l;
        crc_mode = md;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'b0, s_ready}, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d,
                               input logic l, input logic e);
        int n = 0;
        logic [33:0] b;
        while (q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_avail"}, {31'b0, q.size() != 0}, 1);
        if (q.size() != 0) begin
            b = q.pop_front();
            chk({tag, "_data"}, b[31:0], d);
            chk({tag, "_last"}, {31'b0, b[32]}, {31'b0, l});
            chk({tag, "_err"}, {31'b0, b[33]}, {31'b0, e});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", {31'b0, m_valid}, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", {31'b0, m_last}, 0);
        chk("rst_m_err", {31'b0, m_err}, 0);
        chk("rst_s_ready", {31'b0, s_ready}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rel_s_ready", {31'b0, s_ready}, 1);

        // Generate, single beats
        send(32'h0000_0100, 1, 0);
        expect_beat("g1_d", 32'h0000_0100, 0, 0);
        expect_beat("g1_c", 32'h0000_00F4, 1, 0);
        send(32'h0000_0001, 1, 0);
        expect_beat("g2_d", 32'h0000_0001, 0, 0);
        expect_beat("g2_c", 32'h0000_0031, 1, 0);

        // Multi-beat, one bubble, then reseeded packet
        send(32'h0000_0000, 0, 0);
        send(32'h0000_0001, 1, 0);
        @(negedge clk);
        chk("append_ready", {31'b0, s_ready}, 0);
        @(posedge clk);
        #1 chk("after_append_ready", {31'b0, s_ready}, 1);
        send(32'h0000_0002, 1, 0);
        expect_beat("m0", 32'h0000_0000, 0, 0);
        expect_beat("m1", 32'h0000_0001, 0, 0);
        expect_beat("mc", 32'h0000_0031, 1, 0);
        expect_beat("r0", 32'h0000_0002, 0, 0);
        expect_beat("rc", 32'h0000_0062, 1, 0);

        // Check mode
        send(32'h0000_0100, 0, 1);
        send(32'h0000_00F4, 1, 1);
        expect_beat("c1_d", 32'h0000_0100, 0, 0);
        expect_beat("c1_c", 32'h0000_00F4, 1, 0);
        send(32'h0000_0100, 0, 1);
        send(32'hFFFF_FFF4, 1, 1);
        expect_beat("c2_d", 32'h0000_0100, 0, 0);
        expect_beat("c2_c", 32'hFFFF_FFF4, 1, 0);
        send(32'h0000_0100, 0, 1);
        send(32'h0000_00F5, 1, 1);
        expect_beat("c3_d", 32'h0000_0100, 0, 0);
        expect_beat("c3_c", 32'h0000_00F5, 1, 1);
        repeat (2) @(negedge clk);
        chk("err_clear", {31'b0, m_err}, 0);

        // Backpressure mid-packet and during APPEND
        @(posedge clk);
        #1 m_ready = 1'b0;
        s_valid  = 1'b1;
        s_data   = 32'h0000_0000;
        s_last   = 1'b0;
        crc_mode = 1'b0;
        @(posedge clk);
        #1;
        s_data = 32'h0000_0001;
        s_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp1_ready", {31'b0, s_ready}, 0);
            chk("bp1_valid", {31'b0, m_valid}, 1);
            chk("bp1_data", m_data, 32'h0000_0000);
            chk("bp1_last", {31'b0, m_last}, 0);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", {31'b0, s_ready}, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp2_ready", {31'b0, s_ready}, 0);
            chk("bp2_data", m_data, 32'h0000_0001);
            chk("bp2_last", {31'b0, m_last}, 0);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        expect_beat("bp_0", 32'h0000_0000, 0, 0);
        expect_beat("bp_1", 32'h0000_0001, 0, 0);
        expect_beat("bp_c", 32'h0000_0031, 1, 0);

        // Mode toggled mid-packet is ignored; next packet takes it
        send(32'h0000_0000, 0, 0);
        send(32'h0000_0001, 1, 1);
        expect_beat("ms0", 32'h0000_0000, 0, 0);
        expect_beat("ms1", 32'h0000_0001, 0, 0);
        expect_beat("msc", 32'h0000_0031, 1, 0);
        send(32'h0000_0001, 0, 1);
        send(32'h0000_0031, 1, 0);
        expect_beat("mk0", 32'h0000_0001, 0, 0);
        expect_beat("mk1", 32'h0000_0031, 1, 0);

        // Reset after first of three beats
        send(32'h0000_0100, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mr_m_valid", {31'b0, m_valid}, 0);
        chk("mr_m_data", m_data, 0);
        chk("mr_m_last", {31'b0, m_last}, 0);
        chk("mr_s_ready", {31'b0, s_ready}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mr_no_residue", q.size(), 0);
        send(32'h0000_0100, 1, 0);
        expect_beat("mr_d", 32'h0000_0100, 0, 0);
        expect_beat("mr_c", 32'h0000_00F4, 1, 0);
        repeat (5) @(negedge clk);
        chk("tail_empty", q.size(), 0);
        chk("tail_valid", {31'b0, m_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/crc_stream.md
# crc_stream

Parametrised streaming CRC engine, successor to the fixed 32-bit/CRC-8 single-word encoder. It accepts multi-beat packets on a valid/ready input, computes an MSB-first CRC with configurable width, polynomial and seed, and forwards the data on a registered valid/ready output. It runs in one of two per-packet modes:

- **Generate:** appends a CRC beat to the packet.
- **Check:** compares a received CRC beat against the computed CRC and flags the result.

It sits between a packet source (framer/DMA) and the link serialiser, or the mirror position on receive.

## Interface
- `DW`, default 32: data beat width. Must satisfy `DW >= CW`.
- `CW`, default 8: CRC width.
- `POLY`, default 8'h31: generator polynomial, with the implicit x^CW term omitted.
- `INIT`, default 0: CRC register seed, loaded at every packet start.

Ports (clock and reset first):
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `crc_mode`, in, 1: 0 = generate, 1 = check. Sampled on the first accepted beat of a packet.
- `s_valid`, in, 1: input beat valid.
- `s_ready`, out, 1: input beat accepted when `s_valid && s_ready`.
- `s_data`, in, DW: input beat.
- `s_last`, in, 1: final beat of packet. In check mode this beat is the CRC beat.
- `m_valid`, out, 1: output beat valid.
- `m_ready`, in, 1: downstream accepts the beat.
- `m_data`, out, DW: output beat.
- `m_last`, out, 1: final output beat of packet.
- `m_err`, out, 1: CRC mismatch. Meaningful only on check-mode `m_last` beats; 0 at all other times.

## Operation
- **Per-beat update:** `s_data` bits are processed from DW-1 down to 0.
  - `fb = crc[CW-1] ^ bit`
  - `crc = {crc[CW-2:0],0} ^ (fb ? POLY : 0)`
  - No reflection and no final XOR.
  - With `INIT=0` and a single beat, the result equals the long-division remainder of `{data, CW'b0}` by `{1,POLY}`.
- **CRC register:**
  - Loaded with `INIT` at reset and after each packet completes.
  - The first beat of a packet is computed from `INIT`, not from a stale value.
- **Packet mode:** the mode latched on the first beat holds until the packet's last beat is accepted. Changes to `crc_mode` mid-packet are ignored.
- **Generate mode:**
  - Every input beat passes through unchanged, with `m_last=0`.
  - After the `s_last` beat, one extra beat is emitted: `m_data = {(DW-CW)'b0, crc}`, `m_last=1`, `m_err=0`.
- **Check mode:**
  - Non-last beats pass through and update the CRC.
  - The `s_last` beat does not update the CRC. Its `s_data[CW-1:0]` is compared with the current CRC.
  - The beat is forwarded unchanged with `m_last=1` and `m_err = (mismatch)`. The upper bits of the CRC beat are ignored.
- **States:**
  - IDLE (between packets): first accepted beat → PASS, or directly to completion for a 1-beat packet.
  - PASS (mid-packet): last beat accepted in generate mode → APPEND; in check mode → IDLE.
  - APPEND: CRC beat loaded into the output register → IDLE.
- **1-beat packet in generate mode:** one data beat followed by the CRC beat.
- **1-beat packet in check mode:** the beat is compared against `INIT`.

## Timing
- **Reset values:** `m_valid=0`, `m_data=0`, `m_last=0`, `m_err=0`, `s_ready=0` while `rst_n` is low, crc=`INIT`, state IDLE.
- **Reset mid-packet:** the partial packet is discarded. No CRC beat is emitted afterwards.
- **Output register:** `m_*` is a single register stage with 1-cycle latency from input acceptance to `m_valid`.
- **Input ready:** `s_ready = (state != APPEND) && (!m_valid || m_ready)`. Full throughput is sustained when `m_ready=1`.
- **Holding:** while `m_valid && !m_ready`, `m_data`, `m_last` and `m_err` hold stable and `s_ready=0`.
- **APPEND:** lasts at least 1 cycle. The CRC beat loads when `!m_valid || m_ready`.
  - A generate packet of N beats produces N+1 output beats and causes exactly one input bubble.
- **Back-to-back packets:**
  - A new packet's first beat is accepted the cycle after a check-mode last beat is accepted.
  - In generate mode, it is accepted the cycle after the CRC beat loads.
  - The CRC seed is applied in both cases.
- **Reset release:** `s_ready` asserts the first cycle after `rst_n` deasserts.

## Test plan
- **Generate, default params, `m_ready=1`:** 1-beat packet `0x00000100` → output `0x00000100` (`m_last=0`), then `0x000000F4` (`m_last=1`). Then packet `0x00000001` → CRC beat `0x00000031`.
- **Multi-beat and reseed:** generate packet [`0x00000000`, `0x00000001`] → CRC beat `0x31`. Immediately followed by [`0x00000002`] → CRC beat `0x62`, proving the reseed.
- **Check mode:**
  - [`0x00000100`, `0x000000F4`] → 2 output beats, second with `m_last=1`, `m_err=0`.
  - [`0x00000100`, `0xFFFFFFF4`] → `m_err=0` (upper bits ignored).
  - [`0x00000100`, `0x000000F5`] → `m_err=1`.
- **Backpressure:** hold `m_ready=0` for 5 cycles mid-packet and during APPEND → `m_data` and `m_last` stable, `s_ready=0`, no beats lost or duplicated. Output sequence identical to the `m_ready=1` run.
- **Mode switch:** toggle `crc_mode` mid-packet → the packet keeps its first-beat mode. The next packet uses the new mode.
- **Reset mid-packet:** assert `rst_n=0` after 1 of 3 beats → all outputs 0 immediately. After release, packet `0x00000100` in generate mode → CRC `0xF4` (no residue).
